// File: rtl/safe_controller.sv
// Digital safe controller: synchronised TRY/PROG buttons, key register, failure counting, lockout and optional auto-relock.
// Optional near-miss detection (NEAR state, blue LED) is enabled by defining SAFE_NEAR_MISS_EN.
module safe_controller #(
  parameter logic [3:0] RESET_KEY   = 4'h0,
  parameter int         MAX_FAILS   = 3,
  parameter int         LOCK_CYCLES = 50_000_000,
  parameter int         OPEN_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] ATTEMPT,
  input  logic [3:0] KEY_IN,
  input  logic       TRY,
  input  logic       PROG,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic [3:0] DIFF,
  output logic       NEG,
  output logic [1:0] FAILS,
  output logic       LOCKED
);

  localparam int MAX_CYC = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] OPEN_LOAD  = (OPEN_CYCLES > 0) ? CW'(OPEN_CYCLES - 1) : '0;
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
`ifdef SAFE_NEAR_MISS_EN
    ST_NEAR    = 2'd2,
`endif
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic [3:0]    diff_q, diff_d;
  logic          neg_q, neg_d;
  logic [1:0]    fails_q, fails_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [2:0]    try_sync_q, try_sync_d;
  logic [2:0]    prog_sync_q, prog_sync_d;
  logic          led_r_q, led_r_d;
  logic          led_g_q, led_g_d;
  logic          locked_q, locked_d;

  logic          try_pulse;
  logic          prog_pulse;
  logic          attempt_lt;
  logic [3:0]    eval_diff;
  logic [1:0]    fails_inc;

  // Bits [0] and [1] form the 2-FF synchronizer; bit [2] delays it for edge detection.
  assign try_sync_d  = {try_sync_q[1:0], TRY};
  assign prog_sync_d = {prog_sync_q[1:0], PROG};
  assign try_pulse   = try_sync_q[1] & ~try_sync_q[2];
  assign prog_pulse  = prog_sync_q[1] & ~prog_sync_q[2];

  assign attempt_lt = (ATTEMPT < key_q);
  assign eval_diff  = attempt_lt ? (key_q - ATTEMPT) : (ATTEMPT - key_q);
  assign fails_inc  = fails_q + 2'd1;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    diff_d  = diff_q;
    neg_d   = neg_q;
    fails_d = fails_q;
    timer_d = timer_q;

    case (state_q)
`ifdef SAFE_NEAR_MISS_EN
      ST_CLOSED, ST_NEAR: begin
`else
      ST_CLOSED: begin
`endif
        if (try_pulse) begin
          diff_d = eval_diff;
          neg_d  = attempt_lt;
          if (ATTEMPT == key_q) begin
            state_d = ST_OPEN;
            fails_d = 2'd0;
            timer_d = OPEN_LOAD;
          end
`ifdef SAFE_NEAR_MISS_EN
          else if (eval_diff <= 4'd3) begin
            state_d = ST_NEAR;
          end
`endif
          else begin
            fails_d = fails_inc;
            if (fails_inc == FAIL_LIMIT) begin
              state_d = ST_LOCKOUT;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ST_CLOSED;
            end
          end
        end
      end

      // A PROG pulse takes priority over auto-relock expiring in the same cycle.
      ST_OPEN: begin
        if (prog_pulse) begin
          key_d   = KEY_IN;
          state_d = ST_CLOSED;
          diff_d  = 4'd0;
          neg_d   = 1'b0;
          fails_d = 2'd0;
        end else if (OPEN_CYCLES > 0) begin
          if (timer_q == '0) begin
            state_d = ST_CLOSED;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_CLOSED;
          fails_d = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_CLOSED;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    led_r_d  = (state_d == ST_CLOSED) || (state_d == ST_LOCKOUT);
    led_g_d  = (state_d == ST_OPEN);
    locked_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_CLOSED;
      key_q       <= RESET_KEY;
      diff_q      <= 4'd0;
      neg_q       <= 1'b0;
      fails_q     <= 2'd0;
      timer_q     <= '0;
      try_sync_q  <= 3'b000;
      prog_sync_q <= 3'b000;
      led_r_q     <= 1'b1;
      led_g_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      diff_q      <= diff_d;
      neg_q       <= neg_d;
      fails_q     <= fails_d;
      timer_q     <= timer_d;
      try_sync_q  <= try_sync_d;
      prog_sync_q <= prog_sync_d;
      led_r_q     <= led_r_d;
      led_g_q     <= led_g_d;
      locked_q    <= locked_d;
    end
  end

`ifdef SAFE_NEAR_MISS_EN
  logic led_b_q, led_b_d;

  always_comb begin
    led_b_d = (state_d == ST_NEAR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_b_q <= 1'b0;
    end else begin
      led_b_q <= led_b_d;
    end
  end

  assign LED_B = led_b_q;
`else
  assign LED_B = 1'b0;
`endif

  assign LED_R  = led_r_q;
  assign LED_G  = led_g_q;
  assign DIFF   = diff_q;
  assign NEG    = neg_q;
  assign FAILS  = fails_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_safe_controller.sv
// Scoreboard bench for safe_controller: expected output vectors are queued when stimulus is driven and compared once the DUT has responded.
// A second instance with auto-relock enabled shares the same stimulus.
module tb_safe_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       try_btn;
  logic       prog_btn;
  logic [3:0] attempt;
  logic [3:0] key_in;

  logic       led_r, led_g, led_b, neg, locked;
  logic [3:0] diff;
  logic [1:0] fails;
  logic       led_r_b, led_g_b, led_b_b, neg_b, locked_b;
  logic [3:0] diff_b;
  logic [1:0] fails_b;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;
  int          n;

  always #5 clk = ~clk;

  safe_controller #(
    .RESET_KEY(4'h5), .MAX_FAILS(3), .LOCK_CYCLES(8), .OPEN_CYCLES(0)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .ATTEMPT(attempt), .KEY_IN(key_in),
    .TRY(try_btn), .PROG(prog_btn),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b),
    .DIFF(diff), .NEG(neg), .FAILS(fails), .LOCKED(locked)
  );

  safe_controller #(
    .RESET_KEY(4'h5), .MAX_FAILS(3), .LOCK_CYCLES(8), .OPEN_CYCLES(4)
  ) dut_relock (
    .CLK(clk), .RST_N(rst_n), .ATTEMPT(attempt), .KEY_IN(key_in),
    .TRY(try_btn), .PROG(prog_btn),
    .LED_R(led_r_b), .LED_G(led_g_b), .LED_B(led_b_b),
    .DIFF(diff_b), .NEG(neg_b), .FAILS(fails_b), .LOCKED(locked_b)
  );

  function automatic logic [31:0] pk(input logic r, input logic g, input logic b,
                                     input logic [3:0] d, input logic ng,
                                     input logic [1:0] f, input logic l);
    return {21'd0, r, g, b, d, ng, f, l};
  endfunction

  function automatic logic [31:0] obs_a();
    return pk(led_r, led_g, led_b, diff, neg, fails, locked);
  endfunction

  function automatic logic [31:0] obs_b();
    return pk(led_r_b, led_g_b, led_b_b, diff_b, neg_b, fails_b, locked_b);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    try_btn  = 1'b0;
    prog_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives a one-cycle button press and returns at the first negedge where the result is visible.
  task automatic press(input logic t, input logic p);
    @(negedge clk);
    try_btn  = t;
    prog_btn = p;
    @(negedge clk);
    try_btn  = 1'b0;
    prog_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    attempt = 4'd0;
    key_in  = 4'd0;
    do_reset();
    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL reset_a got %h want %h", obs_a(), exp_v); end
    exp_v = sb.pop_front(); n_checks++;
    if (obs_b() !== exp_v) begin n_fails++; $display("[TB] FAIL reset_b got %h want %h", obs_b(), exp_v); end

    attempt = 4'd5;
    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    @(negedge clk); try_btn = 1'b1;
    @(negedge clk); try_btn = 1'b0;
    @(negedge clk);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL latency_early got %h want %h", obs_a(), exp_v); end
    @(negedge clk);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL open_key5 got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_near();
    do_reset();
    attempt = 4'd3;
`ifdef SAFE_NEAR_MISS_EN
    sb.push_back(pk(0, 0, 1, 4'd2, 1, 2'd0, 0));
`else
    sb.push_back(pk(1, 0, 0, 4'd2, 1, 2'd1, 0));
`endif
    press(1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL near_attempt3 got %h want %h", obs_a(), exp_v); end

    attempt = 4'd5;
    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    press(1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL retry_after_near got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_lockout();
    do_reset();
    attempt = 4'd12;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(pk(1, 0, 0, 4'd7, 0, 2'(i), (i == 3) ? 1'b1 : 1'b0));
      press(1'b1, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL lockout_press%0d got %h want %h", i, obs_a(), exp_v); end
    end

    // A press early in lockout must be ignored; the second press lands on the first cycle after LOCKED falls.
    sb.push_back(32'd8);
    n = 0;
    while (locked === 1'b1 && n < 40) begin
      if (n == 2) try_btn = 1'b1;
      if (n == 3) try_btn = 1'b0;
      if (n == 6) begin attempt = 4'd5; try_btn = 1'b1; end
      if (n == 7) try_btn = 1'b0;
      @(negedge clk);
      n++;
    end
    try_btn = 1'b0;
    exp_v = sb.pop_front(); n_checks++;
    if (32'(n) !== exp_v) begin n_fails++; $display("[TB] FAIL lockout_cycles got %0d want %0d", n, exp_v); end

    sb.push_back(pk(1, 0, 0, 4'd7, 0, 2'd0, 0));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL lockout_exit got %h want %h", obs_a(), exp_v); end

    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    @(negedge clk);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL try_after_lockout got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_program();
    logic [3:0]  atts [6];
    logic [3:0]  keys [6];
    logic [1:0]  pt   [6];
    logic [31:0] exps [6];
    do_reset();
    atts[0] = 4'd5; keys[0] = 4'd0; pt[0] = 2'b10; exps[0] = pk(0, 1, 0, 4'd0, 0, 2'd0, 0);
    atts[1] = 4'd5; keys[1] = 4'd9; pt[1] = 2'b01; exps[1] = pk(1, 0, 0, 4'd0, 0, 2'd0, 0);
    atts[2] = 4'd5; keys[2] = 4'd0; pt[2] = 2'b10; exps[2] = pk(1, 0, 0, 4'd4, 1, 2'd1, 0);
    atts[3] = 4'd9; keys[3] = 4'd0; pt[3] = 2'b10; exps[3] = pk(0, 1, 0, 4'd0, 0, 2'd0, 0);
    atts[4] = 4'd9; keys[4] = 4'd3; pt[4] = 2'b11; exps[4] = pk(1, 0, 0, 4'd0, 0, 2'd0, 0);
    atts[5] = 4'd3; keys[5] = 4'd7; pt[5] = 2'b11; exps[5] = pk(0, 1, 0, 4'd0, 0, 2'd0, 0);
    for (int i = 0; i < 6; i++) begin
      attempt = atts[i];
      key_in  = keys[i];
      sb.push_back(exps[i]);
      press(pt[i][1], pt[i][0]);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL program_step%0d got %h want %h", i, obs_a(), exp_v); end
    end

    attempt = 4'd0;
    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    press(1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL try_in_open got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_reset_lockout();
    do_reset();
    attempt = 4'd5;
    key_in  = 4'd9;
    press(1'b1, 1'b0);
    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    press(1'b0, 1'b1);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL prog_key9 got %h want %h", obs_a(), exp_v); end

    attempt = 4'd0;
    repeat (3) press(1'b1, 1'b0);
    sb.push_back(pk(1, 0, 0, 4'd9, 1, 2'd3, 1));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL lockout_key9 got %h want %h", obs_a(), exp_v); end

    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL async_reset got %h want %h", obs_a(), exp_v); end
    @(negedge clk);
    rst_n = 1'b1;

    attempt = 4'd5;
    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    press(1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL key_restored got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_held();
    do_reset();
    attempt = 4'd12;
    sb.push_back(pk(1, 0, 0, 4'd7, 0, 2'd1, 0));
    @(negedge clk);
    try_btn = 1'b1;
    repeat (20) @(negedge clk);
    try_btn = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL held_try got %h want %h", obs_a(), exp_v); end
  endtask

  task automatic test_auto_relock();
    do_reset();
    attempt = 4'd5;
    press(1'b1, 1'b0);
    sb.push_back(32'd4);
    n = 0;
    while (led_g_b === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp_v = sb.pop_front(); n_checks++;
    if (32'(n) !== exp_v) begin n_fails++; $display("[TB] FAIL relock_cycles got %0d want %0d", n, exp_v); end

    sb.push_back(pk(1, 0, 0, 4'd0, 0, 2'd0, 0));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_b() !== exp_v) begin n_fails++; $display("[TB] FAIL relock_state got %h want %h", obs_b(), exp_v); end

    repeat (10) @(negedge clk);
    sb.push_back(pk(0, 1, 0, 4'd0, 0, 2'd0, 0));
    exp_v = sb.pop_front(); n_checks++;
    if (obs_a() !== exp_v) begin n_fails++; $display("[TB] FAIL stay_open got %h want %h", obs_a(), exp_v); end
  endtask

  initial begin
    rst_n    = 1'b0;
    try_btn  = 1'b0;
    prog_btn = 1'b0;
    attempt  = 4'd0;
    key_in   = 4'd0;
    test_reset();
    test_near();
    test_lockout();
    test_program();
    test_reset_lockout();
    test_held();
    test_auto_relock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
